// File: rtl/wvb_reader_pkg.sv
// Shared waveform-buffer definitions: header field layout, reader state encoding,
// stream marker, skid depth and the header-word formatter.
package wvb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDRW = 2'd1,
    SAMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int HDR_STOP_LSB  = 0;
  localparam int HDR_START_LSB = 12;
  localparam int HDR_LTC_LSB   = 24;
  localparam int HDR_LTC_WIDTH = 48;
  localparam int HDR_TRIG_LSB  = 72;
  localparam int HDR_CNST_BIT  = 74;
  localparam int HDR_WORDS     = 5;

  localparam logic [3:0] HDR_MARKER = 4'hA;
  localparam int         SKID_DEPTH = 4;

  // n12 is the sample count modulo 4096, so a full buffer reads back as 12'h000.
  function automatic logic [15:0] hdr_word(
    input logic [2:0]  idx,
    input logic [11:0] n12,
    input logic [47:0] ltc,
    input logic [1:0]  trig,
    input logic        cnst
  );
    case (idx)
      3'd0:    hdr_word = {HDR_MARKER, n12};
      3'd1:    hdr_word = ltc[47:32];
      3'd2:    hdr_word = ltc[31:16];
      3'd3:    hdr_word = ltc[15:0];
      default: hdr_word = {trig, cnst, 13'b0};
    endcase
  endfunction

endpackage

// File: rtl/wvb_reader_if.sv
// Bus bundle between the waveform reader, the header FIFO, the waveform storage
// and the downstream word sink.
interface wvb_reader_if #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80
);
  logic [P_HDR_WIDTH-1:0]  hdr_data;
  logic                    hdr_empty;
  logic                    hdr_rdreq;
  logic [P_DATA_WIDTH-1:0] wvb_data;
  logic                    wvb_rdreq;
  logic                    wvb_rddone;
  // dout transfers on a clock edge where dout_valid and dout_ready are both 1;
  // once dout_valid rises, dout and dout_valid hold until that transfer happens.
  logic [15:0]             dout;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    input  hdr_data, hdr_empty, wvb_data, dout_ready,
    output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );

  modport slave (
    output hdr_data, hdr_empty, wvb_data, dout_ready,
    input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
  );
endinterface

// File: rtl/wvb_rd_skid_fifo.sv
// Small synchronous show-ahead FIFO that absorbs waveform samples still in
// flight from the storage read pipeline when the output stalls.
module wvb_rd_skid_fifo
  import wvb_reader_pkg::*;
#(
  parameter int P_WIDTH = 22
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [P_WIDTH-1:0]                  din,
  input  logic                                pop,
  output logic [P_WIDTH-1:0]                  dout,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(SKID_DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SKID_DEPTH);

  logic [P_WIDTH-1:0] mem [SKID_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/wvb_reader.sv
// Waveform buffer reader: pops one event header, streams a five-word header and
// then every stored sample as two 16-bit words, and releases the event storage.
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic         busy,
  output state_t       state,
  wvb_reader_if.master bus
);
  localparam int CW = P_ADR_WIDTH + 1;
  localparam int FW = $clog2(SKID_DEPTH + 1);

  logic [P_HDR_WIDTH-1:0]  hdr;
  logic [P_ADR_WIDTH-1:0]  hdr_span;
  logic [CW-1:0]           n_samp;
  logic [CW-1:0]           rd_cnt;
  logic [CW-1:0]           samp_cnt;
  logic [47:0]             ltc;
  logic [1:0]              trig;
  logic                    cnst;
  logic [2:0]              hdr_idx;
  logic                    half;
  logic [P_RD_LATENCY-1:0] pipe;
  logic [FW-1:0]           flight;
  logic [FW:0]             occ;
  logic                    load_ok;
  logic                    issue_ok;
  logic                    capture;

  logic [P_DATA_WIDTH-1:0] fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FW-1:0]           fifo_count;
  logic                    fifo_pop;

  assign hdr      = bus.hdr_data;
  assign hdr_span = hdr[HDR_STOP_LSB +: P_ADR_WIDTH] - hdr[HDR_START_LSB +: P_ADR_WIDTH];
  assign busy     = (state != IDLE);
  assign load_ok  = !bus.dout_valid || bus.dout_ready;
  assign capture  = pipe[P_RD_LATENCY-1];
  // Reads still in the storage pipeline count against the skid space they will need.
  assign occ      = {1'b0, flight} + {1'b0, fifo_count};
  assign issue_ok = (state == SAMP) && (rd_cnt < n_samp) && (occ < (FW+1)'(SKID_DEPTH)) && !fifo_full;
  assign fifo_pop = (state == SAMP) && load_ok && half;

  wvb_rd_skid_fifo #(.P_WIDTH(P_DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   (bus.wvb_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.hdr_rdreq  <= 1'b0;
      bus.wvb_rdreq  <= 1'b0;
      bus.wvb_rddone <= 1'b0;
      bus.dout       <= 16'h0000;
      bus.dout_valid <= 1'b0;
      n_samp         <= '0;
      rd_cnt         <= '0;
      samp_cnt       <= '0;
      ltc            <= '0;
      trig           <= '0;
      cnst           <= 1'b0;
      hdr_idx        <= '0;
      half           <= 1'b0;
      pipe           <= '0;
      flight         <= '0;
    end else begin
      bus.wvb_rdreq <= issue_ok;
      if (issue_ok) rd_cnt <= rd_cnt + 1'b1;
      pipe[0] <= bus.wvb_rdreq;
      for (int i = 1; i < P_RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      flight <= flight + {{(FW-1){1'b0}}, issue_ok} - {{(FW-1){1'b0}}, capture};
      bus.wvb_rddone <= 1'b0;

      case (state)
        IDLE: begin
          // The pop cycle stays in IDLE so hdr_rdreq is never seen outside it.
          if (bus.hdr_rdreq) begin
            bus.hdr_rdreq <= 1'b0;
            hdr_idx       <= '0;
            state         <= HDRW;
          end else if (enable && !bus.hdr_empty) begin
            bus.hdr_rdreq <= 1'b1;
            n_samp        <= {1'b0, hdr_span} + 1'b1;
            ltc           <= hdr[HDR_LTC_LSB +: HDR_LTC_WIDTH];
            trig          <= hdr[HDR_TRIG_LSB +: 2];
            cnst          <= hdr[HDR_CNST_BIT];
            rd_cnt        <= '0;
            samp_cnt      <= '0;
            half          <= 1'b0;
          end
        end

        HDRW: begin
          if (load_ok) begin
            if (hdr_idx < 3'(HDR_WORDS)) begin
              bus.dout       <= hdr_word(hdr_idx, n_samp[11:0], ltc, trig, cnst);
              bus.dout_valid <= 1'b1;
              hdr_idx        <= hdr_idx + 1'b1;
            end else begin
              bus.dout_valid <= 1'b0;
              state          <= SAMP;
            end
          end
        end

        SAMP: begin
          if (load_ok) begin
            if (half) begin
              bus.dout <= fifo_dout[15:0];
              half     <= 1'b0;
              samp_cnt <= samp_cnt + 1'b1;
            end else if (samp_cnt == n_samp) begin
              bus.dout_valid <= 1'b0;
              bus.wvb_rddone <= 1'b1;
              state          <= DONE;
            end else if (!fifo_empty) begin
              bus.dout       <= 16'(fifo_dout[P_DATA_WIDTH-1:16]);
              bus.dout_valid <= 1'b1;
              half           <= 1'b1;
            end else begin
              bus.dout_valid <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Bench for wvb_reader: header FIFO, waveform storage and word sink models with
// a word-level scoreboard built directly from header contents and storage data.
module tb_wvb_reader;
  import wvb_reader_pkg::*;

  localparam int DW  = 22;
  localparam int AW  = 12;
  localparam int HW  = 80;
  localparam int LAT = 2;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   enable = 1'b0;
  logic   busy;
  state_t state;

  wvb_reader_if #(.P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW)) bus ();

  wvb_reader #(
    .P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW), .P_RD_LATENCY(LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .busy   (busy),
    .state  (state),
    .bus    (bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem [4096];
  logic [HW-1:0] hdr_q [$];
  logic [15:0]   exp_q [$];
  int            exp_n_q [$];
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dline [LAT];
  int            stall_pct = 0;
  int            ev_rdreq = 0, ev_words = 0, ev_samples = 0;
  int            rddone_cnt = 0, last_rdreq = 0, last_words = 0;
  logic [15:0]   ev_first [HDR_WORDS];
  logic [15:0]   last_first [HDR_WORDS];
  logic          prev_stall = 1'b0;
  logic [15:0]   prev_dout = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queues a header and the complete word stream the event must produce.
  task automatic push_hdr(input logic [11:0] start, input logic [11:0] stop,
                          input logic [47:0] ltc, input logic [1:0] trig, input logic cnst);
    logic [11:0]   span;
    logic [11:0]   n12;
    logic [DW-1:0] s;
    int            n;
    span = stop - start;
    n    = int'(span) + 1;
    n12  = 12'(n);
    hdr_q.push_back({5'b0, cnst, trig, ltc, start, stop});
    exp_n_q.push_back(n);
    exp_q.push_back({4'hA, n12});
    exp_q.push_back(ltc[47:32]);
    exp_q.push_back(ltc[31:16]);
    exp_q.push_back(ltc[15:0]);
    exp_q.push_back({trig, cnst, 13'b0});
    for (int k = 0; k < n; k++) begin
      s = mem[12'(int'(start) + k)];
      exp_q.push_back({10'b0, s[21:16]});
      exp_q.push_back(s[15:0]);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (!(exp_q.size() == 0 && hdr_q.size() == 0 && !busy) && c < budget) begin
      step(1);
      c++;
    end
    check(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int c = 0;
    while (state != s && c < budget) begin
      step(1);
      c++;
    end
    check(tag, 32'(c < budget), 32'd1);
  endtask

  // Storage, header FIFO and sink models; everything moves at the falling edge.
  initial begin
    logic [DW-1:0] nd;
    int            n;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wvb_rdreq) begin
          check("rdreq_state", 32'(state), 32'(SAMP));
          check("occupancy", 32'((ev_rdreq + 1 - ev_samples) <= 5), 32'd1);
          nd = mem[rd_addr];
          rd_addr = rd_addr + 1'b1;
          ev_rdreq++;
        end else begin
          nd = DW'($urandom);
        end
        bus.wvb_data = dline[LAT-1];
        for (int i = LAT - 1; i > 0; i--) dline[i] = dline[i-1];
        dline[0] = nd;

        if (bus.hdr_rdreq) begin
          check("hdr_rdreq_state", 32'(state), 32'(IDLE));
          check("hdr_avail", 32'(hdr_q.size() > 0), 32'd1);
          if (hdr_q.size() > 0) begin
            rd_addr = hdr_q[0][23:12];
            void'(hdr_q.pop_front());
          end
        end

        bus.dout_ready = ($urandom_range(0, 99) >= stall_pct);
        if (prev_stall) begin
          check("stall_valid", 32'(bus.dout_valid), 32'd1);
          check("stall_dout", 32'(bus.dout), 32'(prev_dout));
        end
        if (bus.dout_valid && bus.dout_ready) begin
          if (exp_q.size() == 0) check("word_extra", {16'h0, bus.dout}, 32'h10000);
          else                   check("word", 32'(bus.dout), 32'(exp_q.pop_front()));
          if (ev_words < HDR_WORDS) ev_first[ev_words] = bus.dout;
          ev_words++;
          if (ev_words > HDR_WORDS && ((ev_words - HDR_WORDS) % 2) == 0) ev_samples++;
        end
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;

        if (bus.wvb_rddone) begin
          rddone_cnt++;
          if (exp_n_q.size() == 0) begin
            check("rddone_extra", 32'(bus.wvb_rddone), 32'd0);
          end else begin
            n = exp_n_q.pop_front();
            check("ev_rdreq", 32'(ev_rdreq), 32'(n));
            check("ev_words", 32'(ev_words), 32'(2 * n + HDR_WORDS));
          end
          last_rdreq = ev_rdreq;
          last_words = ev_words;
          last_first = ev_first;
          ev_rdreq = 0;
          ev_words = 0;
          ev_samples = 0;
        end
      end else begin
        prev_stall = 1'b0;
        bus.dout_ready = 1'b1;
      end
      bus.hdr_empty = (hdr_q.size() == 0);
      bus.hdr_data  = (hdr_q.size() == 0) ? '0 : hdr_q[0];
    end
  end

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_hdr_rdreq"}, 32'(bus.hdr_rdreq), 32'd0);
    check({tag, "_wvb_rdreq"}, 32'(bus.wvb_rdreq), 32'd0);
    check({tag, "_rddone"}, 32'(bus.wvb_rddone), 32'd0);
    check({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int            base;
    logic [11:0]   s;
    logic [47:0]   l;
    foreach (mem[i]) mem[i] = DW'($urandom);
    foreach (dline[i]) dline[i] = '0;
    rd_addr        = '0;
    bus.hdr_data   = '0;
    bus.hdr_empty  = 1'b1;
    bus.wvb_data   = '0;
    bus.dout_ready = 1'b1;

    step(3);
    check_quiet_outputs("reset");
    rst_n = 1'b1;
    step(2);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Basic event with the reference header values.
    enable = 1'b1;
    base = rddone_cnt;
    push_hdr(12'h010, 12'h013, 48'h123456789ABC, 2'd2, 1'b0);
    wait_idle(500, "basic_timeout");
    check("basic_w0", 32'(last_first[0]), 32'hA004);
    check("basic_w1", 32'(last_first[1]), 32'h1234);
    check("basic_w2", 32'(last_first[2]), 32'h5678);
    check("basic_w3", 32'(last_first[3]), 32'h9ABC);
    check("basic_w4", 32'(last_first[4]), 32'h8000);
    check("basic_words", 32'(last_words), 32'd13);
    check("basic_rddone", 32'(rddone_cnt - base), 32'd1);

    // Address wrap.
    push_hdr(12'hFFE, 12'h001, 48'h0000DEADBEEF, 2'd1, 1'b1);
    wait_idle(500, "wrap_timeout");
    check("wrap_w0", 32'(last_first[0]), 32'hA004);
    check("wrap_rdreq", 32'(last_rdreq), 32'd4);

    // Whole buffer.
    push_hdr(12'h000, 12'hFFF, 48'hFEDCBA987654, 2'd3, 1'b1);
    wait_idle(10000, "full_timeout");
    check("full_w0", 32'(last_first[0]), 32'hA000);
    check("full_rdreq", 32'(last_rdreq), 32'd4096);
    check("full_words", 32'(last_words), 32'd8197);

    // Random events with 30% downstream stalls.
    stall_pct = 30;
    base = rddone_cnt;
    for (int e = 0; e < 8; e++) begin
      s = 12'($urandom);
      l = {16'($urandom), $urandom};
      push_hdr(s, 12'(int'(s) + $urandom_range(0, 40)), l, 2'($urandom_range(0, 3)), 1'($urandom));
      if (e == 3) step(30);
    end
    wait_idle(6000, "random_timeout");
    check("random_rddone", 32'(rddone_cnt - base), 32'd8);

    // Header arriving while the previous event is in DONE.
    stall_pct = 0;
    base = rddone_cnt;
    push_hdr(12'h200, 12'h205, 48'h111122223333, 2'd0, 1'b0);
    wait_state(DONE, 500, "done_wait_timeout");
    push_hdr(12'h300, 12'h302, 48'h444455556666, 2'd1, 1'b1);
    wait_idle(500, "done_hdr_timeout");
    check("done_hdr_rddone", 32'(rddone_cnt - base), 32'd2);

    // Enable dropped during the first of two queued events.
    stall_pct = 20;
    enable = 1'b0;
    base = rddone_cnt;
    push_hdr(12'h400, 12'h40F, 48'hAAAA5555AAAA, 2'd2, 1'b0);
    push_hdr(12'h500, 12'h503, 48'h0123456789AB, 2'd3, 1'b1);
    step(5);
    check("enable_low_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_state(HDRW, 50, "enable_start_timeout");
    enable = 1'b0;
    begin
      int c = 0;
      while (rddone_cnt == base && c < 500) begin step(1); c++; end
      check("first_done_timeout", 32'(c < 500), 32'd1);
    end
    step(20);
    check("second_held_busy", 32'(busy), 32'd0);
    check("second_held_queue", 32'(hdr_q.size()), 32'd1);
    check("first_rddone", 32'(rddone_cnt - base), 32'd1);
    enable = 1'b1;
    wait_idle(500, "second_timeout");
    check("second_rddone", 32'(rddone_cnt - base), 32'd2);

    // Asynchronous reset in the middle of sample readout.
    stall_pct = 0;
    base = rddone_cnt;
    push_hdr(12'h600, 12'h613, 48'h0F0F0F0F0F0F, 2'd1, 1'b0);
    wait_state(SAMP, 100, "rst_samp_timeout");
    begin
      int c = 0;
      while (ev_words < 9 && c < 100) begin step(1); c++; end
      check("rst_words_timeout", 32'(c < 100), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet_outputs("async_rst");
    exp_q.delete();
    exp_n_q.delete();
    hdr_q.delete();
    foreach (dline[i]) dline[i] = '0;
    ev_rdreq = 0;
    ev_words = 0;
    ev_samples = 0;
    step(3);
    check_quiet_outputs("held_rst");
    rst_n = 1'b1;
    step(3);
    check("rst_no_rddone", 32'(rddone_cnt - base), 32'd0);
    push_hdr(12'h100, 12'h107, 48'h13579BDF2468, 2'd0, 1'b1);
    wait_idle(500, "after_rst_timeout");
    check("after_rst_rddone", 32'(rddone_cnt - base), 32'd1);
    check("after_rst_rdreq", 32'(last_rdreq), 32'd8);
    check("after_rst_w0", 32'(last_first[0]), 32'hA008);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wvb_reader.md
WVB_READER -- requirements
Module: wvb_reader

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 22, waveform sample width.
REQ-002 SHALL have parameter P_ADR_WIDTH, default 12, waveform address width.
REQ-003 SHALL have parameter P_HDR_WIDTH, default 80, header word width.
REQ-004 SHALL have parameter P_RD_LATENCY, default 2, cycles from wvb_rdreq to valid wvb_data.
REQ-005 SHALL have port clk  in  1  sole clock; one clock domain, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  in  1  permits starting a new event readout.
REQ-008 SHALL have port hdr_data  in  P_HDR_WIDTH  header FIFO head, first-word-fall-through.
REQ-009 SHALL have port hdr_empty  in  1  header FIFO empty.
REQ-010 SHALL have port hdr_rdreq  out  1  header FIFO pop; also loads the storage read address with start_addr.
REQ-011 SHALL have port wvb_data  in  P_DATA_WIDTH  waveform storage read data.
REQ-012 SHALL have port wvb_rdreq  out  1  advances the storage read address by one sample.
REQ-013 SHALL have port wvb_rddone  out  1  one-cycle pulse; current event fully read and its storage released.
REQ-014 SHALL have port dout  out  16  output stream word.
REQ-015 SHALL have port dout_valid  out  1  dout holds a valid word.
REQ-016 SHALL have port dout_ready  in  1  downstream accepts dout.
REQ-017 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL decode the header as: [11:0] stop_addr, [23:12] start_addr, [71:24] ltc, [73:72] trig_src, [74] cnst_run, [79:75] ignored.
REQ-019 SHALL compute n_samp = ((stop_addr - start_addr) mod 2^P_ADR_WIDTH) + 1 in P_ADR_WIDTH+1 bits, range 1..4096; stop < start is an address wrap, not an error.
REQ-020 SHALL implement the states IDLE, HDRW, SAMP and DONE.
REQ-021 In IDLE with enable=1 and hdr_empty=0, SHALL latch hdr_data, pulse hdr_rdreq for exactly one cycle, and enter HDRW on the next cycle.
REQ-022 In HDRW, SHALL emit five words in order: {4'hA, n_samp[11:0]}, ltc[47:32], ltc[31:16], ltc[15:0], {trig_src, cnst_run, 13'b0}; n_samp=4096 is encoded as 12'h000.
REQ-023 SHALL enter SAMP after the fifth header word is accepted.
REQ-024 In SAMP, SHALL emit two words per sample, high word first: {10'b0, data[21:16]}, then data[15:0]; samples are in address order.
REQ-025 SHALL consider a word accepted only in a cycle with dout_valid=1 and dout_ready=1.
REQ-026 SHALL keep dout stable while dout_valid=1 and dout_ready=0.
REQ-027 SHALL assert wvb_rdreq only while in SAMP, only when (outstanding reads + skid FIFO occupancy) < 4, and no more than n_samp times per event.
REQ-028 SHALL sustain one word per cycle when dout_ready is held high; no bubbles after the first sample.
REQ-029 After the low word of the last sample is accepted, SHALL enter DONE, pulse wvb_rddone for one cycle, then return to IDLE.
REQ-030 SHALL always finish an event already in progress, even if enable is deasserted mid-event.
REQ-031 SHALL NOT assert hdr_rdreq while in HDRW, SAMP or DONE.
REQ-032 When hdr_empty deasserts in the same cycle as DONE, SHALL pop the header in IDLE on the following cycle; no header is lost or double-read.

Reset
REQ-033 While rst_n=0, SHALL hold: state IDLE; hdr_rdreq, wvb_rdreq, wvb_rddone, dout_valid, busy = 0; dout = 16'h0000; counters and skid FIFO cleared.
REQ-034 Reset SHALL take effect asynchronously, including mid-event; the partial event is abandoned and wvb_rddone is not pulsed.
REQ-035 SHALL leave the first active edge after rst_n rises as IDLE behaviour.

Structure
REQ-036 SHALL place the header field offsets, state encoding, 4'hA marker and skid depth 4 in the shared waveform-buffer package.
REQ-037 SHALL implement the skid buffer as sub-module wvb_rd_skid_fifo (4 x P_DATA_WIDTH, synchronous, full/empty/count).

Verification
REQ-038 Header start=0x010, stop=0x013, ltc=0x123456789ABC, trig_src=2, dout_ready=1 -> words A004, 1234, 5678, 9ABC, 8000, then 8 sample words; one wvb_rddone pulse.
REQ-039 Wrap: start=0xFFE, stop=0x001 -> n_samp=4, header word A004, exactly 4 wvb_rdreq.
REQ-040 Full buffer: start=0x000, stop=0xFFF -> header word A000, 4096 wvb_rdreq, 8197 words total.
REQ-041 Random dout_ready with 30% stalls -> no lost or duplicated sample, dout stable during stalls, occupancy never > 4.
REQ-042 Two headers queued, enable dropped during the first event -> first event completes with one wvb_rddone; second not started until enable=1.
REQ-043 rst_n low mid-SAMP -> all outputs 0 asynchronously, no wvb_rddone; next header reads cleanly.
